sram_bridge: RTL and testbench

SRAM_BRIDGE -- requirements
Module: sram_bridge

---
 rtl/sram_bridge_pkg.sv | 15 +
 rtl/sram_dq_io.sv | 15 +
 rtl/sram_bridge.sv | 154 +++++++++++++++
 tb/tb_sram_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// rtl/sram_bridge_pkg.sv - shared types and constants for the SRAM bridge
package sram_bridge_pkg;

   // Width of the ACCESS-phase wait counter; holds WAIT-1 for WAIT up to 15.
   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_HOLD,
      ST_IO
   } state_t;

endpackage

// File: rtl/sram_dq_io.sv
// rtl/sram_dq_io.sv - SRAM data bus tristate driver and raw bus read
module sram_dq_io #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] dq_out,
   input  logic          dq_oe,
   output logic [DW-1:0] dq_in,
   inout  wire  [DW-1:0] SRAM_DQ
);

   // Drive only when the registered output-enable is set; otherwise release the bus.
   assign SRAM_DQ = dq_oe ? dq_out : {DW{1'bz}};
   assign dq_in   = SRAM_DQ;

endmodule

// File: rtl/sram_bridge.sv
// rtl/sram_bridge.sv - CPU request to asynchronous SRAM bridge with one I/O register
module sram_bridge
   import sram_bridge_pkg::*;
#(
   parameter int          DW      = 16,
   parameter int          AW      = 20,
   parameter int          WAIT    = 2,
   parameter logic [AW-1:0] IO_ADDR = AW'(20'h0FFFF)
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   input  logic [DW/8-1:0] req_be,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_rdata,
   input  logic [DW-1:0]   sw_in,
   output logic [DW-1:0]   hex_data,
   output logic            SRAM_CE_N,
   output logic            SRAM_OE_N,
   output logic            SRAM_WE_N,
   output logic [DW/8-1:0] SRAM_BE_N,
   output logic [AW-1:0]   SRAM_ADDR,
   inout  wire  [DW-1:0]   SRAM_DQ
);

   generate
      if (DW % 8 != 0) begin : g_dw_check
         $error("sram_bridge: DW must be a multiple of 8");
      end
      if (WAIT < 1 || WAIT > 15) begin : g_wait_check
         $error("sram_bridge: WAIT must be in 1..15");
      end
   endgenerate

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              lat_we;
   logic [DW-1:0]     lat_wdata;
   logic [DW/8-1:0]   lat_be;
   logic [DW-1:0]     dq_out;
   logic              dq_oe;
   logic [DW-1:0]     dq_in;

   // Expand byte enables into a bit mask so disabled lanes read as zero.
   function automatic logic [DW-1:0] be_expand(input logic [DW/8-1:0] be);
      logic [DW-1:0] m;
      m = '0;
      for (int i = 0; i < DW/8; i++) begin
         m[i*8 +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

   assign req_ready = (state == ST_IDLE);

   // Bridge FSM; every SRAM pin and the DQ enable is a flop set on entry to its state.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_wdata <= '0;
         lat_be    <= '0;
         SRAM_CE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_WE_N <= 1'b1;
         SRAM_BE_N <= '1;
         SRAM_ADDR <= '0;
         dq_oe     <= 1'b0;
         dq_out    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         hex_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               rsp_valid <= 1'b0;
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_wdata <= req_wdata;
                  lat_be    <= req_be;
                  if (req_addr == IO_ADDR) begin
                     state     <= ST_IO;
                     rsp_valid <= 1'b1;
                     if (!req_we) begin
                        rsp_rdata <= sw_in & be_expand(req_be);
                     end
                  end else begin
                     state     <= ST_SETUP;
                     SRAM_CE_N <= 1'b0;
                     SRAM_OE_N <= req_we;
                     SRAM_WE_N <= 1'b1;
                     SRAM_BE_N <= ~req_be;
                     SRAM_ADDR <= req_addr;
                  end
               end
            end
            ST_SETUP: begin
               state <= ST_ACCESS;
               cnt   <= CNT_W'(WAIT - 1);
               if (lat_we) begin
                  SRAM_WE_N <= 1'b0;
                  dq_oe     <= 1'b1;
                  dq_out    <= lat_wdata;
               end
            end
            ST_ACCESS: begin
               if (cnt == '0) begin
                  state     <= ST_HOLD;
                  SRAM_WE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  rsp_valid <= 1'b1;
                  if (!lat_we) begin
                     rsp_rdata <= dq_in & be_expand(lat_be);
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               SRAM_CE_N <= 1'b1;
               SRAM_BE_N <= '1;
               dq_oe     <= 1'b0;
            end
            ST_IO: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               if (lat_we) begin
                  hex_data <= (hex_data & ~be_expand(lat_be)) | (lat_wdata & be_expand(lat_be));
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   sram_dq_io #(
      .DW(DW)
   ) u_dq (
      .dq_out  (dq_out),
      .dq_oe   (dq_oe),
      .dq_in   (dq_in),
      .SRAM_DQ (SRAM_DQ)
   );

endmodule

// File: tb/tb_sram_bridge.sv
// tb/tb_sram_bridge.sv - directed self-checking bench for sram_bridge
module tb_sram_bridge;

   logic        Clk;
   logic        Reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [19:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_be;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [15:0] sw_in;
   logic [15:0] hex_data;
   logic        SRAM_CE_N;
   logic        SRAM_OE_N;
   logic        SRAM_WE_N;
   logic [1:0]  SRAM_BE_N;
   logic [19:0] SRAM_ADDR;
   wire  [15:0] sram_dq;

   int total;
   int bad;
   int rsp_cnt;
   int we_low_cnt;
   int r0;
   int w0;

   logic [15:0] mem [0:255];
   logic        mdl_drive;

   sram_bridge #(
      .DW(16), .AW(20), .WAIT(2), .IO_ADDR(20'h0FFFF)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .sw_in     (sw_in),
      .hex_data  (hex_data),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_BE_N (SRAM_BE_N),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ   (sram_dq)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Asynchronous SRAM model: drives on read, stores enabled lanes while WE_N is low.
   assign mdl_drive = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
   assign sram_dq   = mdl_drive ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;

   always @(posedge Clk) begin
      if (!SRAM_CE_N && !SRAM_WE_N) begin
         if (!SRAM_BE_N[0]) mem[SRAM_ADDR[7:0]][7:0]  <= sram_dq[7:0];
         if (!SRAM_BE_N[1]) mem[SRAM_ADDR[7:0]][15:8] <= sram_dq[15:8];
      end
   end

   always @(negedge Clk) begin
      if (rsp_valid)  rsp_cnt    <= rsp_cnt + 1;
      if (!SRAM_WE_N) we_low_cnt <= we_low_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // Present a request in the current IDLE cycle, step past the accept edge.
   task automatic start(input logic we, input logic [19:0] a, input logic [15:0] d,
                        input logic [1:0] be, input logic hold);
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      req_valid = 1'b1;
      check_eq("accept_ready", req_ready, 1);
      tick;
      if (!hold) req_valid = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0; rsp_cnt = 0; we_low_cnt = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      Reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_be = '0; sw_in = 16'h0000;
      tick; tick;

      check_eq("rst_ce",   SRAM_CE_N, 1);
      check_eq("rst_oe",   SRAM_OE_N, 1);
      check_eq("rst_we",   SRAM_WE_N, 1);
      check_eq("rst_be",   SRAM_BE_N, 2'b11);
      check_eq("rst_addr", SRAM_ADDR, 0);
      check_eq("rst_hex",  hex_data, 0);
      check_eq("rst_rsp",  rsp_valid, 0);
      check_eq("rst_oe_q", dut.dq_oe, 0);
      Reset_n = 1'b1;
      tick;

      // SRAM write 0x00010 <= 0xBEEF
      w0 = we_low_cnt;
      start(1'b1, 20'h00010, 16'hBEEF, 2'b11, 1'b0);
      check_eq("wr_setup_ce",   SRAM_CE_N, 0);
      check_eq("wr_setup_we",   SRAM_WE_N, 1);
      check_eq("wr_setup_oe",   SRAM_OE_N, 1);
      check_eq("wr_setup_be",   SRAM_BE_N, 2'b00);
      check_eq("wr_setup_addr", SRAM_ADDR, 20'h00010);
      check_eq("wr_setup_dqz",  dut.dq_oe, 0);
      check_eq("wr_setup_rdy",  req_ready, 0);
      tick;
      check_eq("wr_acc1_we", SRAM_WE_N, 0);
      check_eq("wr_acc1_dq", sram_dq, 16'hBEEF);
      tick;
      check_eq("wr_acc2_we", SRAM_WE_N, 0);
      check_eq("wr_acc2_dq", sram_dq, 16'hBEEF);
      check_eq("wr_acc2_rsp", rsp_valid, 0);
      tick;
      check_eq("wr_hold_rsp", rsp_valid, 1);
      check_eq("wr_hold_we",  SRAM_WE_N, 1);
      check_eq("wr_hold_ce",  SRAM_CE_N, 0);
      check_eq("wr_hold_dq",  sram_dq, 16'hBEEF);
      check_eq("wr_hold_oe_q", dut.dq_oe, 1);
      tick;
      check_eq("wr_idle_rsp",  rsp_valid, 0);
      check_eq("wr_idle_dqz",  dut.dq_oe, 0);
      check_eq("wr_idle_ce",   SRAM_CE_N, 1);
      check_eq("wr_idle_be",   SRAM_BE_N, 2'b11);
      check_eq("wr_idle_addr", SRAM_ADDR, 20'h00010);
      check_eq("wr_idle_rdy",  req_ready, 1);
      check_eq("wr_we_cycles", we_low_cnt - w0, 2);

      // SRAM read 0x00010, low byte only
      start(1'b0, 20'h00010, 16'h0000, 2'b01, 1'b0);
      check_eq("rd_setup_oe",  SRAM_OE_N, 0);
      check_eq("rd_setup_we",  SRAM_WE_N, 1);
      check_eq("rd_setup_be",  SRAM_BE_N, 2'b10);
      check_eq("rd_setup_dqz", dut.dq_oe, 0);
      tick;
      check_eq("rd_acc1_dqz", dut.dq_oe, 0);
      check_eq("rd_acc1_oe",  SRAM_OE_N, 0);
      tick;
      check_eq("rd_acc2_dqz", dut.dq_oe, 0);
      tick;
      check_eq("rd_hold_rsp",   rsp_valid, 1);
      check_eq("rd_hold_rdata", rsp_rdata, 16'h00EF);
      check_eq("rd_hold_dqz",   dut.dq_oe, 0);
      tick;
      check_eq("rd_idle_rsp", rsp_valid, 0);

      // I/O write, full and partial
      start(1'b1, 20'h0FFFF, 16'h1234, 2'b11, 1'b0);
      check_eq("iow_rsp", rsp_valid, 1);
      check_eq("iow_ce",  SRAM_CE_N, 1);
      check_eq("iow_we",  SRAM_WE_N, 1);
      tick;
      check_eq("iow_hex", hex_data, 16'h1234);
      check_eq("iow_rsp_off", rsp_valid, 0);
      check_eq("iow_rdy", req_ready, 1);
      start(1'b1, 20'h0FFFF, 16'h5678, 2'b01, 1'b0);
      tick;
      check_eq("iow_hex_part", hex_data, 16'h1278);

      // I/O read, full and upper byte
      sw_in = 16'hA5A5;
      start(1'b0, 20'h0FFFF, 16'h0000, 2'b11, 1'b0);
      check_eq("ior_rsp",   rsp_valid, 1);
      check_eq("ior_rdata", rsp_rdata, 16'hA5A5);
      check_eq("ior_ce",    SRAM_CE_N, 1);
      tick;
      sw_in = 16'h3C5A;
      start(1'b0, 20'h0FFFF, 16'h0000, 2'b10, 1'b0);
      check_eq("ior_rdata_hi", rsp_rdata, 16'h3C00);
      tick;

      // Write with no byte enables still runs a full cycle
      start(1'b1, 20'h00010, 16'h0000, 2'b00, 1'b0);
      check_eq("be0_ce", SRAM_CE_N, 0);
      check_eq("be0_be", SRAM_BE_N, 2'b11);
      tick; tick; tick;
      check_eq("be0_rsp", rsp_valid, 1);
      tick;
      start(1'b0, 20'h00010, 16'h0000, 2'b11, 1'b0);
      tick; tick; tick;
      check_eq("be0_readback", rsp_rdata, 16'hBEEF);
      tick;

      // Back-to-back write then read with req_valid held
      r0 = rsp_cnt;
      start(1'b1, 20'h00030, 16'hCAFE, 2'b11, 1'b1);
      req_we = 1'b0; req_wdata = 16'h0000;
      tick; tick; tick;
      check_eq("b2b_hold_rdy", req_ready, 0);
      tick;
      check_eq("b2b_idle_rdy", req_ready, 1);
      check_eq("b2b_idle_dqz", dut.dq_oe, 0);
      tick;
      req_valid = 1'b0;
      check_eq("b2b_setup_dqz", dut.dq_oe, 0);
      check_eq("b2b_setup_oe",  SRAM_OE_N, 0);
      check_eq("b2b_setup_we",  SRAM_WE_N, 1);
      tick; tick; tick;
      check_eq("b2b_rd_rsp",   rsp_valid, 1);
      check_eq("b2b_rd_rdata", rsp_rdata, 16'hCAFE);
      tick; tick;
      check_eq("b2b_rsp_count", rsp_cnt - r0, 2);
      check_eq("b2b_end_rdy",   req_ready, 1);

      // Reset during the first ACCESS cycle of a write
      start(1'b1, 20'h00040, 16'h1111, 2'b11, 1'b0);
      tick;
      check_eq("rsw_pre_we", SRAM_WE_N, 0);
      r0 = rsp_cnt;
      #2 Reset_n = 1'b0;
      #1;
      check_eq("rsw_we",   SRAM_WE_N, 1);
      check_eq("rsw_ce",   SRAM_CE_N, 1);
      check_eq("rsw_be",   SRAM_BE_N, 2'b11);
      check_eq("rsw_dqz",  dut.dq_oe, 0);
      check_eq("rsw_addr", SRAM_ADDR, 0);
      check_eq("rsw_hex",  hex_data, 0);
      check_eq("rsw_rsp",  rsp_valid, 0);
      tick;
      Reset_n = 1'b1;
      tick; tick; tick;
      check_eq("rsw_no_rsp", rsp_cnt - r0, 0);
      check_eq("rsw_rdy",    req_ready, 1);
      sw_in = 16'hA5A5;
      start(1'b0, 20'h0FFFF, 16'h0000, 2'b11, 1'b0);
      check_eq("rsw_recover", rsp_rdata, 16'hA5A5);
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
